// File: rtl/sap1_prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : sap1_prog_loader
// Description : Framed byte-stream program loader for the SAP-1 CPU.
//               Receives SYNC, N, N data bytes and a mod-256 checksum over a
//               valid/ready byte interface, writes the data bytes into the
//               CPU's 16x8 RAM, and holds the CPU in reset until the image
//               has been verified. Any framing, count, checksum or idle
//               timeout fault parks the loader in an error state with the
//               CPU still in reset.
// Revision    : 1.0 - initial release
// ============================================================================
module sap1_prog_loader #(
    parameter logic [7:0]  SYNC_BYTE = 8'hA5,
    parameter int unsigned RST_HOLD  = 4,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       ram_we,
    output logic [3:0] ram_addr,
    output logic [7:0] ram_wdata,
    output logic       cpu_rst,
    output logic       done,
    output logic       error
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [3:0] c_rst_hold = RST_HOLD[3:0];
    localparam logic [7:0] c_timeout  = TIMEOUT[7:0];
    localparam logic [7:0] c_max_len  = 8'd16;

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [2:0] {
        ST_HDR  = 3'd0,
        ST_CNT  = 3'd1,
        ST_DATA = 3'd2,
        ST_CSUM = 3'd3,
        ST_HOLD = 3'd4,
        ST_RUN  = 3'd5,
        ST_ERR  = 3'd6
    } state_t;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    state_t     r_state;
    logic [4:0] r_idx;        // 5 bits so a 16-byte image ends at 16, not 0
    logic [4:0] r_len;        // frame length N, 1..16
    logic [7:0] r_sum;        // running mod-256 sum of data bytes
    logic [7:0] r_idle;       // idle cycles since the last accepted byte
    logic [3:0] r_hold_cnt;   // cycles spent in HOLD
    logic       r_ram_we;
    logic [3:0] r_ram_addr;
    logic [7:0] r_ram_wdata;
    logic       r_cpu_rst;
    logic       r_done;
    logic       r_error;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic       w_ready;
    logic       w_accept;
    logic       w_len_ok;
    logic [7:0] w_idle_next;
    logic       w_timeout;
    logic [4:0] w_idx_next;
    logic [7:0] w_sum_next;

    // Ready depends on state alone; the source may hold valid high freely.
    assign w_ready = (r_state == ST_HDR)  || (r_state == ST_CNT) ||
                     (r_state == ST_DATA) || (r_state == ST_CSUM);

    // A start pulse wins over a byte presented in the same cycle.
    assign w_accept    = in_valid && w_ready && !start;

    assign w_len_ok    = (in_data != 8'd0) && (in_data <= c_max_len);
    assign w_idle_next = r_idle + 8'd1;
    assign w_timeout   = (w_idle_next == c_timeout);
    assign w_idx_next  = r_idx + 5'd1;
    assign w_sum_next  = r_sum + in_data;

    // ------------------------------------------------------------------------
    // Output wiring
    // ------------------------------------------------------------------------
    assign in_ready  = w_ready;
    assign ram_we    = r_ram_we;
    assign ram_addr  = r_ram_addr;
    assign ram_wdata = r_ram_wdata;
    assign cpu_rst   = r_cpu_rst;
    assign done      = r_done;
    assign error     = r_error;

    // Loader FSM: frame parsing, RAM writes, checksum, reset hold and errors.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_HDR;
            r_idx       <= 5'd0;
            r_len       <= 5'd0;
            r_sum       <= 8'd0;
            r_idle      <= 8'd0;
            r_hold_cnt  <= 4'd0;
            r_ram_we    <= 1'b0;
            r_ram_addr  <= 4'd0;
            r_ram_wdata <= 8'd0;
            r_cpu_rst   <= 1'b1;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
        end else if (start) begin
            // Abort whatever is in flight and wait for a new frame.
            r_state    <= ST_HDR;
            r_idx      <= 5'd0;
            r_sum      <= 8'd0;
            r_idle     <= 8'd0;
            r_hold_cnt <= 4'd0;
            r_ram_we   <= 1'b0;
            r_cpu_rst  <= 1'b1;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            // The write strobe is a single-cycle pulse.
            r_ram_we <= 1'b0;

            case (r_state)
                ST_HDR: begin
                    // Hunt for the sync marker; everything else is dropped.
                    if (w_accept && (in_data == SYNC_BYTE)) begin
                        r_idle  <= 8'd0;
                        r_state <= ST_CNT;
                    end
                end

                ST_CNT: begin
                    if (w_accept) begin
                        r_idle <= 8'd0;
                        if (w_len_ok) begin
                            r_len   <= in_data[4:0];
                            r_idx   <= 5'd0;
                            r_sum   <= 8'd0;
                            r_state <= ST_DATA;
                        end else begin
                            r_state <= ST_ERR;
                        end
                    end else if (w_timeout) begin
                        r_state <= ST_ERR;
                    end else begin
                        r_idle <= w_idle_next;
                    end
                end

                ST_DATA: begin
                    if (w_accept) begin
                        r_idle      <= 8'd0;
                        r_ram_we    <= 1'b1;
                        r_ram_addr  <= r_idx[3:0];
                        r_ram_wdata <= in_data;
                        r_sum       <= w_sum_next;
                        r_idx       <= w_idx_next;
                        if (w_idx_next == r_len) begin
                            r_state <= ST_CSUM;
                        end
                    end else if (w_timeout) begin
                        r_state <= ST_ERR;
                    end else begin
                        r_idle <= w_idle_next;
                    end
                end

                ST_CSUM: begin
                    if (w_accept) begin
                        r_idle <= 8'd0;
                        if (in_data == r_sum) begin
                            r_hold_cnt <= 4'd0;
                            r_state    <= ST_HOLD;
                        end else begin
                            r_state <= ST_ERR;
                        end
                    end else if (w_timeout) begin
                        r_state <= ST_ERR;
                    end else begin
                        r_idle <= w_idle_next;
                    end
                end

                ST_HOLD: begin
                    // Keep the CPU in reset for the hold window, then release
                    // it with done rising on the same edge.
                    if (r_hold_cnt == c_rst_hold) begin
                        r_cpu_rst <= 1'b0;
                        r_done    <= 1'b1;
                        r_state   <= ST_RUN;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 4'd1;
                    end
                end

                ST_RUN: begin
                    r_cpu_rst <= 1'b0;
                    r_done    <= 1'b1;
                end

                ST_ERR: begin
                    r_error   <= 1'b1;
                    r_cpu_rst <= 1'b1;
                end

                default: begin
                    r_state <= ST_HDR;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/sap1_prog_loader.md
# sap1_prog_loader

Byte-stream program loader directly upstream of the SAP-1 microprogrammed CPU. It receives a framed program image over a valid/ready byte interface and writes it into the CPU's 16x8 program/data RAM. It checks a modular checksum and holds the CPU in reset until the image is verified. On success it releases the CPU to fetch from address 0; on any framing, count or checksum fault it keeps the CPU in reset and flags an error.

## Interface
Parameters:
- SYNC_BYTE, 8'hA5, frame start marker
- RST_HOLD, 4, cycles `cpu_rst` stays high after checksum pass (1..15)
- TIMEOUT, 255, max idle cycles between bytes inside a frame (1..255)

Ports:
- clk  input  1  single system clock, all state changes on rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  one-cycle pulse; aborts or restarts a load from any state
- in_valid  input  1  source has a byte on `in_data`
- in_data  input  8  stream byte
- in_ready  output  1  loader accepts byte this cycle
- ram_we  output  1  write strobe to CPU RAM
- ram_addr  output  4  write address
- ram_wdata  output  8  write data
- cpu_rst  output  1  reset to CPU (active-high)
- done  output  1  image loaded and CPU released
- error  output  1  load failed; sticky until `start` or `rst`

## Operation
- Frame layout: SYNC_BYTE, N (valid range 1..16), N data bytes for addresses 0..N-1, CK = (sum of data bytes) mod 256.
- A byte is accepted on a rising edge where `in_valid && in_ready`.
- States and transitions:
  - HDR: `in_ready`=1. SYNC_BYTE -> CNT. Any other byte is consumed and ignored.
  - CNT: N in 1..16 -> DATA, with idx=0 and sum=0. N=0 or N>16 -> ERR.
  - DATA: each byte writes RAM[idx], adds to the 8-bit sum with wrap, and increments idx. After byte N-1 -> CSUM.
  - CSUM: CK==sum -> HOLD; mismatch -> ERR.
  - HOLD: `in_ready`=0. Counts RST_HOLD cycles, then -> RUN.
  - RUN: `cpu_rst`=0 and `done`=1. `in_ready`=0; stream bytes are not consumed.
  - ERR: `error`=1, `cpu_rst`=1, `in_ready`=0.
- `start` has priority over every transition. From any state it goes to HDR, asserts `cpu_rst`, and clears `done`, `error`, idx, sum and the timeout counter. A byte presented in the same cycle as `start` is not accepted.
- Timeout: in CNT, DATA and CSUM, each cycle with no accepted byte increments the idle counter. When it reaches TIMEOUT -> ERR. Every accepted byte clears it. HDR has no timeout.
- `cpu_rst` is 1 in every state except RUN.
- RAM locations at or above N are not written and keep their prior contents.

## Timing
- Reset values: state=HDR, `in_ready`=1, `ram_we`=0, `ram_addr`=0, `ram_wdata`=0, `cpu_rst`=1, `done`=0, `error`=0.
- `ram_we`, `ram_addr` and `ram_wdata` are registered. The write strobe is a one-cycle pulse in the cycle after the data byte is accepted.
- `in_ready` is a combinational decode of state only, never of `in_valid`. The source may hold `in_valid` high back-to-back, giving one byte per cycle.
- Latency, with edge k = the edge that accepts CK:
  - pass: `cpu_rst` stays 1 through RST_HOLD cycles; on edge k+RST_HOLD+1, `cpu_rst` falls and `done` rises together.
  - mismatch: `error` rises on edge k+1.
- Minimum frame with N=1: 4 accepted bytes.
- Asserting `rst` mid-frame immediately returns every output to its reset value. RAM contents are left as written; the loader does not clear RAM.
- idx is 5-bit internally so that N=16 ends at idx=16 without wrapping. `ram_addr` carries idx[3:0].

## Test plan
- Good image: A5,04,09,1A,1B,E0,1E, back-to-back -> writes RAM[0..3]=09,1A,1B,E0; `cpu_rst` falls with `done`=1 exactly RST_HOLD+1 cycles after 1E is accepted; `error`=0.
- Bad checksum: A5,01,FF,00 -> no further writes after RAM[0]=FF; `error`=1 one cycle after CK; `cpu_rst` stays 1; `in_ready`=0.
- Count bounds: A5,00 and, separately, A5,11 -> `error`=1 with no `ram_we` pulse. A5,10 followed by 16 bytes 00..0F and CK=78 -> addresses 0..F written, `done`=1.
- Junk and sync search: 00,FF,A5,01,3C,3C -> the first two bytes are ignored; RAM[0]=3C; `done`=1.
- Timeout and restart: A5,02,11, then `in_valid`=0 for TIMEOUT cycles -> `error`=1. Then a `start` pulse -> `error`=0, `in_ready`=1, and a following good frame loads.
- Reset mid-operation and throttling: `rst` during DATA -> all outputs return to reset values. Then a good frame sent with `in_valid` toggling every other cycle -> the same RAM contents and `done` as the back-to-back case.
